seg7_scan_driver: RTL



---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_decode.sv | 13 +
 rtl/seg7_scan_driver.sv | 134 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment patterns ({g,f,e,d,c,b,a}, 1 = lit)
// and the BCD-to-segment mapping used by the decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [6:0] SEG_ALL  = 7'h7F;

  // Non-BCD codes render as a centre dash so a bad value is visible on the glass.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segments converter; flags nibbles outside 0..9.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o,
  output logic       invalid_o
);

  assign seg_o     = bcd_to_seg(bcd_i);
  assign invalid_o = (bcd_i > 4'd9);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scanner: double-buffered BCD capture, per-digit
// decode, leading-zero blanking, lamp test, anti-ghost blanking and pin polarity.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 2,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYC    = 1,
  parameter bit COMMON_ANODE = 1'b0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [4*N_DIGITS-1:0]   BCD_IN,
  input  logic                    LOAD,
  input  logic                    BLANK_LZ,
  input  logic                    LT,
  output logic [6:0]              SEG,
  output logic [N_DIGITS-1:0]     DIG,
  output logic                    FRAME,
  output logic                    ERR
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [6:0]          SEG_POL = COMMON_ANODE ? 7'h7F : 7'h00;
  localparam logic [N_DIGITS-1:0] DIG_POL = COMMON_ANODE ? {N_DIGITS{1'b1}} : '0;

  logic                  started_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*N_DIGITS-1:0] active_q, active_d;
  logic [6:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   dig_q, dig_d;
  logic                  frame_q, frame_d;
  logic                  err_q, err_d;

  logic                  cnt_wrap, idx_wrap, boundary;
  logic [6:0]            dig_seg [N_DIGITS];
  logic [N_DIGITS-1:0]   dig_bad;
  logic [N_DIGITS-1:0]   lz_zero;
  logic                  zero_run;
  logic [6:0]            cur_seg;
  logic                  cur_blank;

  assign cnt_wrap = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign idx_wrap = (idx_q == IDX_W'(N_DIGITS - 1));
  // The first edge after reset opens a frame at slot (0,0) without advancing.
  assign boundary = !started_q || (cnt_wrap && idx_wrap);

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!started_q) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_wrap) begin
      cnt_d = '0;
      idx_d = idx_wrap ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign shadow_d = LOAD ? BCD_IN : shadow_q;
  assign active_d = boundary ? shadow_q : active_q;

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_dec
    seg7_decode u_dec (
      .bcd_i     (active_d[4*k +: 4]),
      .seg_o     (dig_seg[k]),
      .invalid_o (dig_bad[k])
    );
  end

  // lz_zero[k]: digit k and every more significant digit hold zero.
  always_comb begin
    zero_run = 1'b1;
    lz_zero  = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_run   = zero_run && (active_d[4*k +: 4] == 4'd0);
      lz_zero[k] = zero_run;
    end
  end

  always_comb begin
    cur_seg   = SEG_OFF;
    cur_blank = 1'b0;
    dig_d     = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        cur_seg   = dig_seg[k];
        cur_blank = BLANK_LZ && (k != 0) && lz_zero[k];
        dig_d[k]  = (int'(cnt_d) >= BLANK_CYC);
      end
    end
    if (LT)             seg_d = SEG_ALL;
    else if (cur_blank) seg_d = SEG_OFF;
    else                seg_d = cur_seg;
  end

  assign frame_d = boundary;
  assign err_d   = err_q | (|dig_bad);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      started_q <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      seg_q     <= SEG_OFF ^ SEG_POL;
      dig_q     <= DIG_POL;
      frame_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      started_q <= 1'b1;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      seg_q     <= seg_d ^ SEG_POL;
      dig_q     <= dig_d ^ DIG_POL;
      frame_q   <= frame_d;
      err_q     <= err_d;
    end
  end

  assign SEG   = seg_q;
  assign DIG   = dig_q;
  assign FRAME = frame_q;
  assign ERR   = err_q;

endmodule
